// File: rtl/imm_ext_pkg.sv
// imm_ext_pkg
// Shared constants for the immediate extender:
//   - extension mode encodings carried on in_mode
//   - occupancy encoding of the 2-entry output buffer
package imm_ext_pkg;

  localparam logic [1:0] IMM_SIGN   = 2'b00;
  localparam logic [1:0] IMM_ZERO   = 2'b01;
  localparam logic [1:0] IMM_UPPER  = 2'b10;
  localparam logic [1:0] IMM_BRANCH = 2'b11;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/imm_ext_core.sv
// imm_ext_core
// Purely combinational immediate extension.
// Parameters: IN_W (2 .. OUT_W-2), OUT_W (>= IN_W+2)
// Ports:
//   imm  in  IN_W   raw immediate
//   mode in  2      SIGN / ZERO / UPPER / BRANCH
//   ext  out OUT_W  extended value
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  imm,
  input  logic [1:0]       mode,
  output logic [OUT_W-1:0] ext
);

  logic [OUT_W-1:0] sign_ext;
  logic [OUT_W-1:0] zero_ext;
  logic [OUT_W-1:0] upper_ext;

  assign sign_ext  = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
  assign zero_ext  = {{(OUT_W-IN_W){1'b0}}, imm};
  assign upper_ext = {imm, {(OUT_W-IN_W){1'b0}}};

  always_comb begin
    // NOTE: default assignment first so no path through the case can infer a latch.
    ext = sign_ext;
    case (mode)
      IMM_SIGN:   ext = sign_ext;
      IMM_ZERO:   ext = zero_ext;
      IMM_UPPER:  ext = upper_ext;
      IMM_BRANCH: ext = sign_ext << 2;  // top two bits fall off
      default:    ext = sign_ext;
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe
// Immediate extender with a 2-entry output FIFO so the consumer can stall.
// Results are extended at accept time; the buffer holds extended values.
// Optional feature: define IMMEXT_CNT_EN to add the xfer_cnt port, a 16-bit
// wrapping count of accepted inputs.
// Ports:
//   Clk       in   rising-edge clock
//   Reset_n   in   asynchronous active-low reset
//   in_valid  in   in_imm/in_mode valid
//   in_ready  out  buffer not full (depends on state only)
//   in_imm    in   IN_W raw immediate
//   in_mode   in   2-bit extension mode
//   out_valid out  buffer not empty
//   out_ready in   consumer takes out_data
//   out_data  out  OUT_W head entry
//   xfer_cnt  out  16-bit accept count (IMMEXT_CNT_EN only)
module imm_extend_pipe
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data
`ifdef IMMEXT_CNT_EN
  ,
  output logic [15:0]      xfer_cnt
`endif
);

  occ_e             state;
  logic [OUT_W-1:0] head;
  logic [OUT_W-1:0] tail;
  logic [OUT_W-1:0] ext;
  logic             push;
  logic             pop;

  imm_ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .imm  (in_imm),
    .mode (in_mode),
    .ext  (ext)
  );

  // Both flags derive from the state register only, so no input reaches them
  // combinationally.
  assign in_ready  = (state != OCC_TWO);
  assign out_valid = (state != OCC_EMPTY);
  assign out_data  = head;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      // NOTE: the two entries are reset because out_data must read 0 in reset;
      // a plain storage array with no such visibility would not need it.
      state <= OCC_EMPTY;
      head  <= '0;
      tail  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from
      // pre-edge values, e.g. head <= tail in TWO sees the old tail.
      case (state)
        OCC_EMPTY: begin
          if (push) begin
            head  <= ext;
            state <= OCC_ONE;
          end
        end
        OCC_ONE: begin
          case ({push, pop})
            2'b10: begin
              tail  <= ext;
              state <= OCC_TWO;
            end
            2'b01: state <= OCC_EMPTY;
            2'b11: head <= ext;  // old head leaves, new result takes its place
            default: ;
          endcase
        end
        OCC_TWO: begin
          if (pop) begin
            head  <= tail;
            state <= OCC_ONE;
          end
        end
        default: state <= OCC_EMPTY;
      endcase
    end
  end

`ifdef IMMEXT_CNT_EN
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      xfer_cnt <= '0;
    end else if (push) begin
      xfer_cnt <= xfer_cnt + 16'd1;  // wraps naturally at 16 bits
    end
  end
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb_imm_extend_pipe
// Scoreboard bench: stimulus pushes hand-computed results into a queue, a
// monitor pops and compares whenever a result is released. A second instance
// covers IN_W=12 / OUT_W=24. Counter checks only when IMMEXT_CNT_EN is defined.
module tb_imm_extend_pipe;

  localparam logic [1:0] M_SIGN   = 2'b00;
  localparam logic [1:0] M_ZERO   = 2'b01;
  localparam logic [1:0] M_UPPER  = 2'b10;
  localparam logic [1:0] M_BRANCH = 2'b11;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_imm;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
`ifdef IMMEXT_CNT_EN
  logic [15:0] xfer_cnt;
`endif

  logic        in_valid2;
  logic        in_ready2;
  logic [11:0] in_imm2;
  logic [1:0]  in_mode2;
  logic        out_valid2;
  logic        out_ready2;
  logic [23:0] out_data2;

  always #5 Clk = ~Clk;

  imm_extend_pipe #(.IN_W(16), .OUT_W(32)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_imm    (in_imm),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef IMMEXT_CNT_EN
    ,
    .xfer_cnt  (xfer_cnt)
`endif
  );

  imm_extend_pipe #(.IN_W(12), .OUT_W(24)) dut2 (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .in_valid  (in_valid2),
    .in_ready  (in_ready2),
    .in_imm    (in_imm2),
    .in_mode   (in_mode2),
    .out_valid (out_valid2),
    .out_ready (out_ready2),
    .out_data  (out_data2)
`ifdef IMMEXT_CNT_EN
    ,
    .xfer_cnt  ()
`endif
  );

  typedef struct {
    logic [31:0] data;
    int          acc;
  } exp_t;

  exp_t        sb_q[$];
  logic [23:0] sb_q2[$];
  int          vectors    = 0;
  int          miscompares = 0;
  int          cyc        = 0;
  bit          lat_chk    = 1'b0;

  always @(posedge Clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor for the 16/32 instance: order, value, latency and stall stability.
  initial begin
    bit          stalled = 1'b0;
    logic [31:0] held    = '0;
    exp_t        e;
    forever begin
      @(negedge Clk);
      #1;
      if (!Reset_n) begin
        stalled = 1'b0;
      end else if (out_valid) begin
        if (stalled) check("stall_hold", out_data, held);
        stalled = !out_ready;
        held    = out_data;
        if (out_ready) begin
          if (sb_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_out: got 0x%08h, expected no result", out_data);
          end else begin
            e = sb_q.pop_front();
            check("out_data", out_data, e.data);
            if (lat_chk) check("latency", 32'(cyc), 32'(e.acc));
          end
        end
      end else begin
        stalled = 1'b0;
      end
    end
  end

  // Monitor for the 12/24 instance.
  initial begin
    forever begin
      @(negedge Clk);
      #1;
      if (Reset_n && out_valid2 && out_ready2) begin
        if (sb_q2.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_out2: got 0x%06h, expected no result", out_data2);
        end else begin
          check("out_data2", 32'(out_data2), 32'(sb_q2.pop_front()));
        end
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after the accept.
  task automatic send(input logic [15:0] imm, input logic [1:0] mode, input logic [31:0] exp);
    int   n = 0;
    exp_t e;
    in_valid = 1'b1;
    in_imm   = imm;
    in_mode  = mode;
    while (!in_ready && n < 50) begin
      @(negedge Clk);
      n++;
    end
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: in_ready stuck at 0, expected 1 within 50 cycles");
    end else begin
      e.data = exp;
      e.acc  = cyc + 1;
      sb_q.push_back(e);
    end
    @(negedge Clk);
    in_valid = 1'b0;
    in_imm   = 16'($urandom);
    in_mode  = 2'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge Clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset_n    = 1'b0;
    in_valid   = 1'b1;  // must be ignored during reset
    in_imm     = 16'h5555;
    in_mode    = M_ZERO;
    out_ready  = 1'b1;
    in_valid2  = 1'b0;
    in_imm2    = '0;
    in_mode2   = M_SIGN;
    out_ready2 = 1'b1;

    #3;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  out_data,       32'd0);
`ifdef IMMEXT_CNT_EN
    check("rst_xfer_cnt",  32'(xfer_cnt),  32'd0);
`endif
    idle(2);
    check("rst_ignore_valid", 32'(out_valid), 32'd0);
    in_valid = 1'b0;
    Reset_n  = 1'b1;

    // Basic modes, one-cycle latency, out_ready held high.
    lat_chk = 1'b1;
    send(16'h8001, M_SIGN,   32'hFFFF8001);
    send(16'h8001, M_ZERO,   32'h00008001);
    send(16'h1234, M_UPPER,  32'h12340000);
    send(16'hFFFF, M_BRANCH, 32'hFFFFFFFC);
    send(16'h7FFF, M_SIGN,   32'h00007FFF);
    send(16'hFFFF, M_UPPER,  32'hFFFF0000);
    send(16'h4000, M_BRANCH, 32'h00010000);
    send(16'h8000, M_BRANCH, 32'hFFFE0000);
    idle(2);
    lat_chk = 1'b0;
    check("idle_out_valid", 32'(out_valid), 32'd0);

    // Narrow instance.
    in_valid2 = 1'b1;
    in_imm2   = 12'h800;
    in_mode2  = M_BRANCH;
    check("in_ready2", 32'(in_ready2), 32'd1);
    sb_q2.push_back(24'hFFE000);
    @(negedge Clk);
    in_imm2   = 12'h7FF;
    in_mode2  = M_SIGN;
    sb_q2.push_back(24'h0007FF);
    @(negedge Clk);
    in_valid2 = 1'b0;
    idle(2);
    check("sb_q2_empty", 32'(sb_q2.size()), 32'd0);

    // Back-pressure: two fill the buffer, the third waits for out_ready.
    out_ready = 1'b0;
    send(16'h00AA, M_ZERO, 32'h000000AA);
    send(16'h8000, M_SIGN, 32'hFFFF8000);
    check("full_in_ready", 32'(in_ready), 32'd0);
    fork
      send(16'h00FF, M_UPPER, 32'h00FF0000);
      begin
        idle(3);
        check("stall_in_ready", 32'(in_ready), 32'd0);
        check("stall_head",     out_data,      32'h000000AA);
        out_ready = 1'b1;
      end
    join
    idle(3);
    check("bp_drained", 32'(out_valid), 32'd0);

    // Simultaneous push and pop in ONE.
    out_ready = 1'b0;
    send(16'h0F0F, M_ZERO, 32'h00000F0F);
    out_ready = 1'b1;
    send(16'hF0F0, M_UPPER, 32'hF0F00000);
    check("pp_out_valid", 32'(out_valid), 32'd1);
    check("pp_in_ready",  32'(in_ready),  32'd1);
    check("pp_head",      out_data,       32'hF0F00000);
    idle(2);
    check("pp_drained", 32'(out_valid), 32'd0);

    // Reset while full.
    out_ready = 1'b0;
    send(16'h1111, M_ZERO, 32'h00001111);
    send(16'h2222, M_ZERO, 32'h00002222);
    in_valid = 1'b1;
    in_imm   = 16'h3333;
    in_mode  = M_SIGN;
    #2;
    Reset_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_out_data",  out_data,       32'd0);
    check("arst_in_ready",  32'(in_ready),  32'd1);
    sb_q.delete();
    idle(2);
    in_valid = 1'b0;
    Reset_n  = 1'b1;
    check("post_rst_out_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    lat_chk   = 1'b1;
    send(16'hFFFE, M_BRANCH, 32'hFFFFFFF8);
    idle(2);
    lat_chk = 1'b0;

`ifdef IMMEXT_CNT_EN
    begin
      int acc = 0;
      int guard = 0;
      exp_t e;
      Reset_n = 1'b0;
      #1;
      Reset_n = 1'b1;
      @(negedge Clk);
      in_valid  = 1'b1;
      in_imm    = 16'h0001;
      in_mode   = M_ZERO;
      out_ready = 1'b0;
      e.data    = 32'h00000001;
      repeat (5) begin
        if (in_ready) begin
          e.acc = cyc + 1;
          sb_q.push_back(e);
          acc++;
        end
        @(negedge Clk);
      end
      check("cnt_blocked", 32'(xfer_cnt), 32'd2);
      out_ready = 1'b1;
      while (acc < 65537 && guard < 70000) begin
        if (in_ready) begin
          e.acc = cyc + 1;
          sb_q.push_back(e);
          acc++;
        end
        guard++;
        @(negedge Clk);
      end
      in_valid = 1'b0;
      check("cnt_wrap", 32'(xfer_cnt), 32'd1);
      idle(3);
    end
`endif

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
